// File: rtl/crc_pkg.sv
// crc_pkg: shared FSM state type and default CRC-8 constants for the serial CRC engine.
package crc_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} crc_state_t;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
endpackage

// File: rtl/crc_bit_step.sv
// crc_bit_step: combinational one-bit LFSR update (crc_i, bit_in -> crc_o) built from XOR terms only.
module crc_bit_step #(
  parameter int               CRC_W = 8,
  parameter logic [CRC_W-1:0] POLY  = 8'h07
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_o
);
  logic fb;
  always_comb begin
    fb    = crc_i[CRC_W-1] ^ bit_in;
    crc_o = {crc_i[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{fb}});
  end
endmodule

// File: rtl/crc_serial_engine.sv
// crc_serial_engine: bit-serial CRC over DATA_W-bit words; in_* handshake feeds words, out_* hands off the final CRC; `CRC_REFLECT_EN selects LSB-first input with reflected output.
module crc_serial_engine
  import crc_pkg::*;
#(
  parameter int               CRC_W  = 8,
  parameter int               DATA_W = 8,
  parameter logic [CRC_W-1:0] POLY   = CRC8_POLY,
  parameter logic [CRC_W-1:0] INIT   = CRC8_INIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  crc_state_t        state_q, state_d;
  logic [CRC_W-1:0]  crc_q, crc_d, crc_nx;
  logic [DATA_W-1:0] sh_q, sh_d, sh_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d, data_bit;
  crc_bit_step #(.CRC_W(CRC_W), .POLY(POLY)) u_step (.crc_i(crc_q), .bit_in(data_bit), .crc_o(crc_nx));
`ifdef CRC_REFLECT_EN
  always_comb begin
    data_bit = sh_q[0];
    sh_nx    = sh_q >> 1;
    for (int i = 0; i < CRC_W; i++) out_crc[i] = crc_q[CRC_W-1-i];
  end
`else
  always_comb begin
    data_bit = sh_q[DATA_W-1];
    sh_nx    = sh_q << 1;
    out_crc  = crc_q;
  end
`endif
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (clear) begin
      state_d = IDLE;
      crc_d   = INIT;
      cnt_d   = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sh_d    = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          crc_d = crc_nx;
          sh_d  = sh_nx;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = last_q ? DONE : IDLE;
        end
        DONE: if (out_ready) begin
          crc_d   = INIT;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Handshake outputs are registered copies of the next state.
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      sh_q        <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// tb_crc_serial_engine: scoreboard bench for crc_serial_engine with directed CRC-8 vectors.
module tb_crc_serial_engine;
  logic       clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic [7:0] in_data = 0, out_crc;
  logic       in_ready, out_valid;
  int         n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];

  crc_serial_engine dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_crc(out_crc)
  );

  always #5 clk = ~clk;

  // In reflected builds feeding a bit-reversed word reproduces the MSB-first register,
  // so the expected output is simply the reversed hand-computed CRC.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction
`ifdef CRC_REFLECT_EN
  function automatic logic [7:0] mode8(input logic [7:0] v); return rev8(v); endfunction
`else
  function automatic logic [7:0] mode8(input logic [7:0] v); return v; endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h, expected no output", out_crc);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("result_crc", out_crc, e);
      end
    end
  end

  task automatic accept(input logic [7:0] d, input logic l);
    int n;
    in_data  = mode8(d);
    in_last  = l;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_data  = ~in_data;
    in_last  = ~l;
  endtask

  // Accepts one word and counts busy cycles until the engine is ready or has a result.
  task automatic word(input logic [7:0] d, input logic l);
    int n;
    accept(d, l);
    n = 0;
    while (!in_ready && !out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check(l ? "latency_last" : "busy_cycles", n, 8);
  endtask

  task automatic msg1(input logic [7:0] d, input logic [7:0] crc);
    exp_q.push_back(mode8(crc));
    word(d, 1);
  endtask

  initial begin
    logic [7:0] s[9];
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    #12 rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_crc", out_crc, 8'h00);

    msg1(8'h01, 8'h07);
    repeat (2) @(posedge clk); #1;
    msg1(8'hFF, 8'hF3);
    repeat (2) @(posedge clk); #1;
    msg1(8'h00, 8'h00);
    repeat (2) @(posedge clk); #1;

    exp_q.push_back(mode8(8'hF4));
    for (int i = 0; i < 9; i++) word(s[i], i == 8);
    repeat (2) @(posedge clk); #1;

    out_ready = 0;
    word(8'h01, 1);
    in_valid = 1;
    in_data  = 8'hAA;
    in_last  = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i % 3 == 0) begin
        check("hold_valid", out_valid, 1);
        check("hold_crc", out_crc, mode8(8'h07));
        check("hold_in_ready", in_ready, 0);
      end
    end
    in_valid = 0;
    exp_q.push_back(mode8(8'h07));
    out_ready = 1;
    @(posedge clk); #1;
    check("handoff_valid_fall", out_valid, 0);
    check("handoff_crc_init", out_crc, 8'h00);
    check("handoff_in_ready", in_ready, 1);

    clear = 1;
    in_valid = 1;
    in_data = 8'h55;
    in_last = 1;
    @(posedge clk); #1;
    clear = 0;
    in_valid = 0;
    check("clear_beats_valid", in_ready, 1);
    repeat (10) @(posedge clk); #1;
    check("clear_no_output", out_valid, 0);

    accept(8'h5A, 1);
    repeat (3) @(posedge clk); #1;
    clear = 1;
    @(posedge clk); #1;
    clear = 0;
    check("clear_in_ready", in_ready, 1);
    check("clear_crc", out_crc, 8'h00);
    repeat (12) @(posedge clk); #1;
    check("clear_discard", out_valid, 0);
    msg1(8'h01, 8'h07);
    repeat (2) @(posedge clk); #1;

    accept(8'hC3, 1);
    repeat (4) @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_crc", out_crc, 8'h00);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (12) @(posedge clk); #1;
    check("rst_discard", out_valid, 0);
    msg1(8'h01, 8'h07);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
